banked_mem_ctrl: RTL and testbench
==================================

// Module: banked_mem_ctrl
// PURPOSE
//  Parametrised N-bank interleaved on-chip data memory, shared by the scalar CPU port and an N-lane vector port.
//  Vector lanes carry arbitrary byte addresses; lanes that hit the same bank are serialised, one round per cycle.
//  Sits between CPU/VPU and on-chip SRAM; the SDRAM window is decoded upstream.
// PARAMETERS
//  NUM_BANKS   4             banks = vector lanes; power of 2, >=2
//  BANK_WORDS  1024          words per bank; power of 2
//  DATA_W      32            word width; multiple of 8
//  ADDR_W      32            byte-address width
// PORTS
//  clk            in   1                  single clock
//  resetn         in   1                  asynchronous, active-low reset
//  cpu_req        in   1                  CPU access request
//  cpu_we         in   1                  1=write, 0=read
//  cpu_addr       in   ADDR_W             byte address
//  cpu_wdata      in   DATA_W             write data
//  cpu_wstrb      in   DATA_W/8           byte enables
//  cpu_waitrequest out 1                  request not accepted this cycle
//  cpu_rdata      out  DATA_W             read data
//  cpu_rvalid     out  1                  cpu_rdata valid (1-cycle pulse)
//  vec_req        in   1                  vector transaction request; hold until vec_done
//  vec_we         in   1                  1=store, 0=load (all lanes)
//  vec_lane_en    in   NUM_BANKS          per-lane enable
//  vec_addr       in   NUM_BANKS*ADDR_W   per-lane byte address, lane i at [i*ADDR_W +: ADDR_W]
//  vec_wdata      in   NUM_BANKS*DATA_W   per-lane store data (full-word writes)
//  vec_rdata      out  NUM_BANKS*DATA_W   per-lane load data; held until next transaction
//  vec_done       out  1                  1-cycle pulse: transaction complete
//  addr_err       out  1                  sticky: an out-of-range access occurred
// BEHAVIOUR
//  - Map: word = addr[ADDR_W-1:2]; bank = word[BB-1:0]; local = word[BB +: WB]; BB=log2(NUM_BANKS), WB=log2(BANK_WORDS).
//  - Range: word >= NUM_BANKS*BANK_WORDS is out of range: write dropped, read returns 0, addr_err set.
//  - Reset: state IDLE; pending mask, cpu_rdata, cpu_rvalid, vec_rdata, vec_done, addr_err = 0. RAM contents not cleared.
//  - FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//    IDLE: vec_req=1 -> capture we/addr/wdata; pending = vec_lane_en; go ISSUE.
//      vec_req=1 with vec_lane_en=0 -> go DONE directly.
//      Otherwise serve the CPU.
//    ISSUE: per bank, grant the lowest-index pending lane targeting that bank; issue all grants in parallel.
//      Clear granted bits. pending==0 after the round -> DRAIN.
//    DRAIN: last round's RAM data returns. Each granted lane latches its read data one cycle after its issue.
//    DONE: vec_done=1 for one cycle; go IDLE.
//  - Vector latency: R rounds (max lanes per bank) -> vec_done in cycle R+2 after acceptance (R=1 -> T3).
//  - Disabled lanes: vec_rdata lane = 0. Out-of-range lanes: consume no round, read 0.
//  - Same-address lane writes: serialised in ascending lane order; the highest lane's data persists.
//  - CPU: cpu_waitrequest = (state!=IDLE) | vec_req. The vector port wins a same-cycle tie.
//    Accepted read: cpu_rvalid=1 with data the next cycle. Accepted write: byte-masked by cpu_wstrb, no rvalid.
//    Back-to-back accepts, 1 per cycle.
//  - vec_req dropped before vec_done: ignored; the transaction completes. Inputs are sampled only at acceptance.
//  - Reset mid-operation: abort immediately to reset values. Rounds already issued stay written.
// STRUCTURE
//  - banked_mem_pkg: state_t enum, bank_of()/local_of()/in_range() functions, width localparams.
//  - Sub-module mem_bank: single-port synchronous RAM, BANK_WORDS x DATA_W, byte enables, 1-cycle read latency.
//    Instantiated NUM_BANKS times via generate.
//  - Top: FSM, pending mask, per-bank priority-encoder grant, lane/bank crossbar muxes, read-return lane tags.
// TESTING (NUM_BANKS=4)
//  1. CPU write 0xDEADBEEF @0x10, strb 1111; write 0x0000AA00, strb 0010; read @0x10
//     -> cpu_rvalid next cycle, data 0xDEADAAEF.
//  2. Vector store then load, addrs 0x0/0x4/0x8/0xC, all lanes -> each vec_done 3 cycles after accept;
//     load returns the stored words.
//  3. Vector load, addrs 0x00/0x10/0x20/0x30 (all bank0) -> 4 rounds, vec_done at T6, lanes correct.
//  4. Vector store, all lanes @0x40, data 1/2/3/4; CPU read @0x40 -> 0x4.
//  5. cpu_req and vec_req in the same cycle -> waitrequest high through vec_done; CPU accepted in the following IDLE cycle.
//  6. Reset mid-ISSUE of test 3 -> outputs 0, IDLE, next request completes normally.
//     Read @0x4000 -> data 0, addr_err=1.

Source files
------------

// File: rtl/banked_mem_ctrl_pkg.sv
// rtl/banked_mem_ctrl_pkg.sv - shared types and address-map helpers for the banked memory controller
//
// Purpose : FSM state encoding, byte width, and the word/bank/local address split
//           used by the controller and its RAM banks.
// Ports   : none (package).

package banked_mem_ctrl_pkg;

   localparam int BYTE_W     = 8;
   localparam int ADDR_EXT_W = 64;

   typedef logic [ADDR_EXT_W-1:0] addr_ext_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bank index: low bb bits of the word address.
   function automatic logic [31:0] bank_of(input addr_ext_t addr, input int bb);
      addr_ext_t mask;
      mask = (addr_ext_t'(1) << bb) - addr_ext_t'(1);
      return 32'((addr >> 2) & mask);
   endfunction

   // Word index inside a bank: the wb bits above the bank index.
   function automatic logic [31:0] local_of(input addr_ext_t addr, input int bb, input int wb);
      addr_ext_t mask;
      mask = (addr_ext_t'(1) << wb) - addr_ext_t'(1);
      return 32'((addr >> (2 + bb)) & mask);
   endfunction

   // Word address must fall inside the nb*bw words actually backed by RAM.
   function automatic logic in_range(input addr_ext_t addr, input int nb, input int bw);
      return (addr >> 2) < (addr_ext_t'(nb) * addr_ext_t'(bw));
   endfunction

endpackage

// File: rtl/banked_mem_ctrl_if.sv
// rtl/banked_mem_ctrl_if.sv - CPU and vector port bundle of the banked memory controller
//
// Purpose : groups the scalar CPU port and the N-lane vector port.
// Ports   : cpu_req/we/addr/wdata/wstrb -> controller; cpu_waitrequest/rdata/rvalid <- controller
//           vec_req/we/lane_en/addr/wdata -> controller; vec_rdata/done, addr_err <- controller
//           master = CPU/VPU side, slave = controller side.

interface banked_mem_ctrl_if #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32
);

   logic                          cpu_req;
   logic                          cpu_we;
   logic [ADDR_W-1:0]             cpu_addr;
   logic [DATA_W-1:0]             cpu_wdata;
   logic [DATA_W/8-1:0]           cpu_wstrb;
   logic                          cpu_waitrequest;
   logic [DATA_W-1:0]             cpu_rdata;
   logic                          cpu_rvalid;

   logic                          vec_req;
   logic                          vec_we;
   logic [NUM_BANKS-1:0]          vec_lane_en;
   logic [NUM_BANKS*ADDR_W-1:0]   vec_addr;
   logic [NUM_BANKS*DATA_W-1:0]   vec_wdata;
   logic [NUM_BANKS*DATA_W-1:0]   vec_rdata;
   logic                          vec_done;
   logic                          addr_err;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
      input  cpu_waitrequest, cpu_rdata, cpu_rvalid,
      output vec_req, vec_we, vec_lane_en, vec_addr, vec_wdata,
      input  vec_rdata, vec_done, addr_err
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
      output cpu_waitrequest, cpu_rdata, cpu_rvalid,
      input  vec_req, vec_we, vec_lane_en, vec_addr, vec_wdata,
      output vec_rdata, vec_done, addr_err
   );

endinterface

// File: rtl/banked_mem_ctrl_mem_bank.sv
// rtl/banked_mem_ctrl_mem_bank.sv - single-port synchronous RAM bank with byte enables
//
// Purpose : one WORDS x DATA_W bank, 1-cycle read latency, contents not reset.
// Ports   : clk; en (access), we (1=write), addr (word in bank), wdata, be (byte enables);
//           rdata (read data, valid the cycle after a read access).

module mem_bank
   import banked_mem_ctrl_pkg::*;
#(
   parameter int WORDS  = 1024,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [$clog2(WORDS)-1:0]   addr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/BYTE_W-1:0]   be,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int k = 0; k < DATA_W/BYTE_W; k++) begin
               if (be[k]) begin
                  mem[addr][k*BYTE_W +: BYTE_W] <= wdata[k*BYTE_W +: BYTE_W];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/banked_mem_ctrl.sv
// rtl/banked_mem_ctrl.sv - N-bank interleaved data memory shared by a CPU port and an N-lane vector port
//
// Purpose : word-interleaved banks; vector lanes hitting the same bank are serialised,
//           one round per cycle, lowest lane first. The CPU is served only while idle.
// Ports   : clk, resetn (async, active-low); bus (banked_mem_ctrl_if.slave) carrying
//           the CPU request/response and the vector request/response signals.

module banked_mem_ctrl
   import banked_mem_ctrl_pkg::*;
#(
   parameter int NUM_BANKS  = 4,
   parameter int BANK_WORDS = 1024,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32
) (
   input  logic               clk,
   input  logic               resetn,
   banked_mem_ctrl_if.slave   bus
);

   localparam int BB     = $clog2(NUM_BANKS);
   localparam int WB     = $clog2(BANK_WORDS);
   localparam int STRB_W = DATA_W / BYTE_W;

   state_t                 state;
   logic [NUM_BANKS-1:0]   pending;
   logic                   v_we;
   logic [ADDR_W-1:0]      v_addr  [NUM_BANKS];
   logic [DATA_W-1:0]      v_wdata [NUM_BANKS];

   // Read-return tags: which lane each bank's output belongs to next cycle.
   logic [NUM_BANKS-1:0]   ret_valid;
   logic [BB-1:0]          ret_lane [NUM_BANKS];
   logic                   cpu_ret_oor;
   logic [BB-1:0]          cpu_ret_bank;

   logic                   cpu_rvalid_q;
   logic [DATA_W-1:0]      vec_rdata_q [NUM_BANKS];
   logic                   vec_done_q;
   logic                   addr_err_q;

   logic [BB-1:0]          lane_bank  [NUM_BANKS];
   logic [WB-1:0]          lane_local [NUM_BANKS];
   logic [NUM_BANKS-1:0]   in_ok;

   logic [NUM_BANKS-1:0]   grant_valid;
   logic [BB-1:0]          grant_lane [NUM_BANKS];
   logic [NUM_BANKS-1:0]   grant_mask;
   logic [NUM_BANKS-1:0]   pending_next;
   logic [NUM_BANKS-1:0]   accept_mask;

   logic                   cpu_acc;
   logic                   cpu_ok;
   logic [BB-1:0]          cpu_bank;
   logic [WB-1:0]          cpu_local;

   logic [NUM_BANKS-1:0]   bank_en;
   logic [NUM_BANKS-1:0]   bank_we;
   logic [WB-1:0]          bank_addr  [NUM_BANKS];
   logic [DATA_W-1:0]      bank_wdata [NUM_BANKS];
   logic [STRB_W-1:0]      bank_be    [NUM_BANKS];
   logic [DATA_W-1:0]      bank_q     [NUM_BANKS];

   logic [NUM_BANKS*DATA_W-1:0] vec_rdata_flat;

   // Captured lane addresses drive the crossbar; live addresses only feed the range check at acceptance.
   always_comb begin
      for (int i = 0; i < NUM_BANKS; i++) begin
         lane_bank[i]  = BB'(bank_of(addr_ext_t'(v_addr[i]), BB));
         lane_local[i] = WB'(local_of(addr_ext_t'(v_addr[i]), BB, WB));
         in_ok[i]      = in_range(addr_ext_t'(bus.vec_addr[i*ADDR_W +: ADDR_W]), NUM_BANKS, BANK_WORDS);
      end
   end

   // Per-bank priority encoder: scanning downwards leaves the lowest pending lane as the grant.
   always_comb begin
      grant_valid = '0;
      grant_mask  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         grant_lane[b] = '0;
         for (int i = NUM_BANKS-1; i >= 0; i--) begin
            if (pending[i] && lane_bank[i] == BB'(b)) begin
               grant_valid[b] = 1'b1;
               grant_lane[b]  = BB'(i);
            end
         end
         if (grant_valid[b]) begin
            grant_mask[grant_lane[b]] = 1'b1;
         end
      end
   end

   assign pending_next = pending & ~grant_mask;
   assign accept_mask  = bus.vec_lane_en & in_ok;

   assign cpu_acc   = (state == IDLE) && !bus.vec_req && bus.cpu_req;
   assign cpu_ok    = in_range(addr_ext_t'(bus.cpu_addr), NUM_BANKS, BANK_WORDS);
   assign cpu_bank  = BB'(bank_of(addr_ext_t'(bus.cpu_addr), BB));
   assign cpu_local = WB'(local_of(addr_ext_t'(bus.cpu_addr), BB, WB));

   // Crossbar: vector rounds and CPU accesses never overlap (CPU is only accepted in IDLE).
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_en[b]    = 1'b0;
         bank_we[b]    = 1'b0;
         bank_addr[b]  = '0;
         bank_wdata[b] = '0;
         bank_be[b]    = '0;
         if (state == ISSUE && grant_valid[b]) begin
            bank_en[b]    = 1'b1;
            bank_we[b]    = v_we;
            bank_addr[b]  = lane_local[grant_lane[b]];
            bank_wdata[b] = v_wdata[grant_lane[b]];
            bank_be[b]    = '1;
         end else if (cpu_acc && cpu_ok && cpu_bank == BB'(b)) begin
            bank_en[b]    = 1'b1;
            bank_we[b]    = bus.cpu_we;
            bank_addr[b]  = cpu_local;
            bank_wdata[b] = bus.cpu_wdata;
            bank_be[b]    = bus.cpu_wstrb;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      mem_bank #(
         .WORDS  (BANK_WORDS),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk   (clk),
         .en    (bank_en[b]),
         .we    (bank_we[b]),
         .addr  (bank_addr[b]),
         .wdata (bank_wdata[b]),
         .be    (bank_be[b]),
         .rdata (bank_q[b])
      );
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         pending      <= '0;
         v_we         <= 1'b0;
         ret_valid    <= '0;
         cpu_ret_oor  <= 1'b0;
         cpu_ret_bank <= '0;
         cpu_rvalid_q <= 1'b0;
         vec_done_q   <= 1'b0;
         addr_err_q   <= 1'b0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            v_addr[i]      <= '0;
            v_wdata[i]     <= '0;
            ret_lane[i]    <= '0;
            vec_rdata_q[i] <= '0;
         end
      end else begin
         cpu_rvalid_q <= 1'b0;
         vec_done_q   <= 1'b0;
         ret_valid    <= '0;

         for (int b = 0; b < NUM_BANKS; b++) begin
            if (ret_valid[b]) begin
               vec_rdata_q[ret_lane[b]] <= bank_q[b];
            end
         end

         if (cpu_acc) begin
            if (!cpu_ok) begin
               addr_err_q <= 1'b1;
            end
            if (!bus.cpu_we) begin
               cpu_rvalid_q <= 1'b1;
               cpu_ret_oor  <= !cpu_ok;
               cpu_ret_bank <= cpu_bank;
            end
         end

         case (state)
            IDLE: begin
               if (bus.vec_req) begin
                  v_we <= bus.vec_we;
                  for (int i = 0; i < NUM_BANKS; i++) begin
                     v_addr[i]      <= bus.vec_addr[i*ADDR_W +: ADDR_W];
                     v_wdata[i]     <= bus.vec_wdata[i*DATA_W +: DATA_W];
                     vec_rdata_q[i] <= '0;
                  end
                  // Out-of-range lanes never enter the pending mask, so they cost no round.
                  pending <= accept_mask;
                  if (|(bus.vec_lane_en & ~in_ok)) begin
                     addr_err_q <= 1'b1;
                  end
                  if (accept_mask == '0) begin
                     state      <= DONE;
                     vec_done_q <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               pending <= pending_next;
               if (!v_we) begin
                  ret_valid <= grant_valid;
                  for (int b = 0; b < NUM_BANKS; b++) begin
                     ret_lane[b] <= grant_lane[b];
                  end
               end
               if (pending_next == '0) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state      <= DONE;
               vec_done_q <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      vec_rdata_flat = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         vec_rdata_flat[i*DATA_W +: DATA_W] = vec_rdata_q[i];
      end
   end

   assign bus.cpu_waitrequest = (state != IDLE) | bus.vec_req;
   assign bus.cpu_rvalid      = cpu_rvalid_q;
   assign bus.cpu_rdata       = (cpu_rvalid_q && !cpu_ret_oor) ? bank_q[cpu_ret_bank] : '0;
   assign bus.vec_rdata       = vec_rdata_flat;
   assign bus.vec_done        = vec_done_q;
   assign bus.addr_err        = addr_err_q;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb/tb_banked_mem_ctrl.sv - directed and randomized bench for banked_mem_ctrl against a word-array model

module tb_banked_mem_ctrl;

   localparam int NB    = 4;
   localparam int BW    = 1024;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int TOTAL = NB * BW;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   banked_mem_ctrl_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) bus ();

   banked_mem_ctrl #(
      .NUM_BANKS  (NB),
      .BANK_WORDS (BW),
      .DATA_W     (DW),
      .ADDR_W     (AW)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] ref_mem [TOTAL];
   bit          ref_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >> 2) < 32'(TOTAL);
   endfunction

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_wstrb = s;
      if (in_rng(a)) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) ref_mem[a >> 2][8*k +: 8] = d[8*k +: 8];
         end
      end else begin
         ref_err = 1'b1;
      end
   endtask

   task automatic cpu_idle();
      @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] a, input string tag, output logic [31:0] obs);
      logic [31:0] exp;
      exp = in_rng(a) ? ref_mem[a >> 2] : 32'h0;
      if (!in_rng(a)) ref_err = 1'b1;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = a;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      obs = bus.cpu_rdata;
      check({tag, "_rvalid"}, 64'(bus.cpu_rvalid), 64'd1);
      check({tag, "_rdata"}, 64'(obs), 64'(exp));
      check({tag, "_err"}, 64'(bus.addr_err), 64'(ref_err));
   endtask

   // Latency is derived from the busiest bank: R rounds -> done R+2 cycles after acceptance.
   task automatic vec_op(input bit we, input logic [3:0] en, input logic [127:0] a,
                         input logic [127:0] d, input string tag, input bit with_cpu);
      int          cnt [NB];
      int          r;
      int          exp_lat;
      int          cyc;
      bit          done;
      bit          wait_hi;
      bit          rv_seen;
      logic [31:0] exp_rd [NB];
      logic [31:0] la;
      r = 0;
      for (int b = 0; b < NB; b++) cnt[b] = 0;
      for (int i = 0; i < NB; i++) begin
         la        = a[i*32 +: 32];
         exp_rd[i] = 32'h0;
         if (en[i] && in_rng(la)) begin
            cnt[int'((la >> 2) % NB)]++;
            if (!we) exp_rd[i] = ref_mem[la >> 2];
         end else if (en[i]) begin
            ref_err = 1'b1;
         end
      end
      for (int b = 0; b < NB; b++) if (cnt[b] > r) r = cnt[b];
      exp_lat = (r == 0) ? 1 : r + 2;
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            la = a[i*32 +: 32];
            if (en[i] && in_rng(la)) ref_mem[la >> 2] = d[i*32 +: 32];
         end
      end
      @(negedge clk);
      bus.vec_req     = 1'b1;
      bus.vec_we      = we;
      bus.vec_lane_en = en;
      bus.vec_addr    = a;
      bus.vec_wdata   = d;
      if (with_cpu) begin
         bus.cpu_req = 1'b1;
         bus.cpu_we  = 1'b0;
      end
      cyc     = 0;
      done    = 1'b0;
      wait_hi = 1'b1;
      rv_seen = 1'b0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (!bus.cpu_waitrequest) wait_hi = 1'b0;
         if (bus.cpu_rvalid) rv_seen = 1'b1;
         if (bus.vec_done) done = 1'b1;
      end
      bus.vec_req = 1'b0;
      check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      if (!we) begin
         for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_lane%0d", tag, i), 64'(bus.vec_rdata[i*32 +: 32]), 64'(exp_rd[i]));
         end
      end
      check({tag, "_err"}, 64'(bus.addr_err), 64'(ref_err));
      if (with_cpu) begin
         check({tag, "_waitreq_high"}, 64'(wait_hi), 64'd1);
         check({tag, "_no_cpu_rvalid"}, 64'(rv_seen), 64'd0);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 15) == 0) return 32'h4000 + (32'($urandom_range(0, 255)) << 2);
      return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  obs;
      logic [127:0] va;
      logic [127:0] vd;

      ref_err         = 1'b0;
      resetn          = 1'b0;
      bus.cpu_req     = 1'b0;
      bus.cpu_we      = 1'b0;
      bus.cpu_addr    = '0;
      bus.cpu_wdata   = '0;
      bus.cpu_wstrb   = '0;
      bus.vec_req     = 1'b0;
      bus.vec_we      = 1'b0;
      bus.vec_lane_en = '0;
      bus.vec_addr    = '0;
      bus.vec_wdata   = '0;
      repeat (3) @(negedge clk);
      check("reset_rvalid", 64'(bus.cpu_rvalid), 64'd0);
      check("reset_done", 64'(bus.vec_done), 64'd0);
      check("reset_err", 64'(bus.addr_err), 64'd0);
      check("reset_vrdata", 64'(|bus.vec_rdata), 64'd0);
      check("reset_waitreq", 64'(bus.cpu_waitrequest), 64'd0);
      resetn = 1'b1;

      // Back-to-back fill of the 64-word working window.
      for (int w = 0; w < 64; w++) cpu_write(32'(w) << 2, $urandom, 4'hF);
      cpu_idle();

      // Byte-masked merge.
      cpu_write(32'h10, 32'hDEADBEEF, 4'b1111);
      cpu_write(32'h10, 32'h0000AA00, 4'b0010);
      cpu_idle();
      cpu_read(32'h10, "t1", obs);
      check("t1_literal", 64'(obs), 64'hDEADAAEF);
      @(negedge clk);
      check("t1_rvalid_pulse", 64'(bus.cpu_rvalid), 64'd0);

      // One round per transaction: all lanes in distinct banks.
      va = {32'hC, 32'h8, 32'h4, 32'h0};
      vd = {$urandom, $urandom, $urandom, $urandom};
      vec_op(1'b1, 4'hF, va, vd, "t2_store", 1'b0);
      vec_op(1'b0, 4'hF, va, '0, "t2_load", 1'b0);

      // All lanes in bank 0: four rounds.
      va = {32'h30, 32'h20, 32'h10, 32'h00};
      vec_op(1'b0, 4'hF, va, '0, "t3_load", 1'b0);

      // Same-address stores: highest lane persists.
      va = {4{32'h40}};
      vd = {32'd4, 32'd3, 32'd2, 32'd1};
      vec_op(1'b1, 4'hF, va, vd, "t4_store", 1'b0);
      cpu_read(32'h40, "t4", obs);
      check("t4_literal", 64'(obs), 64'h4);

      // Same-cycle tie: vector wins, CPU read accepted in the following IDLE cycle.
      bus.cpu_addr = 32'h40;
      vec_op(1'b0, 4'b0101, {32'h0, 32'h24, 32'h0, 32'h14}, '0, "t5_vec", 1'b1);
      @(negedge clk);
      check("t5_idle_waitreq", 64'(bus.cpu_waitrequest), 64'd0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      check("t5_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
      check("t5_cpu_rdata", 64'(bus.cpu_rdata), 64'h4);

      // Empty lane mask completes in one cycle.
      vec_op(1'b0, 4'h0, va, '0, "empty", 1'b0);

      // Randomized mix against the model.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: begin
               cpu_write(rnd_addr(), $urandom, 4'($urandom_range(0, 15)));
               cpu_idle();
            end
            1: cpu_read(rnd_addr(), $sformatf("rnd%0d_cpu", n), obs);
            default: begin
               for (int i = 0; i < NB; i++) begin
                  va[i*32 +: 32] = rnd_addr();
                  vd[i*32 +: 32] = $urandom;
               end
               vec_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), va, vd,
                      $sformatf("rnd%0d_vec", n), 1'b0);
            end
         endcase
      end

      // Reset in the middle of a four-round load.
      va = {32'h30, 32'h20, 32'h10, 32'h00};
      @(negedge clk);
      bus.vec_req     = 1'b1;
      bus.vec_we      = 1'b0;
      bus.vec_lane_en = 4'hF;
      bus.vec_addr    = va;
      repeat (2) @(negedge clk);
      resetn      = 1'b0;
      bus.vec_req = 1'b0;
      #1;
      check("t6_rst_done", 64'(bus.vec_done), 64'd0);
      check("t6_rst_rvalid", 64'(bus.cpu_rvalid), 64'd0);
      check("t6_rst_vrdata", 64'(|bus.vec_rdata), 64'd0);
      check("t6_rst_err", 64'(bus.addr_err), 64'd0);
      check("t6_rst_waitreq", 64'(bus.cpu_waitrequest), 64'd0);
      @(negedge clk);
      resetn  = 1'b1;
      ref_err = 1'b0;
      vec_op(1'b0, 4'hF, va, '0, "t6_load", 1'b0);
      cpu_read(32'h4000, "t6_oor", obs);
      check("t6_oor_literal", 64'(obs), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
